alu_xor: RTL and testbench
==========================

ALU_XOR -- requirements
Module: alu_xor

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 clk  input  1  Sole clock; all registered outputs update on its rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high; clears all registered state immediately.
REQ-004 rs1  input  XLEN  Source operand 1.
REQ-005 rs2  input  XLEN  Source operand 2.
REQ-006 in_valid  input  1  Operands are valid this cycle and are captured on the next rising clk edge.
REQ-007 rd  output  XLEN  Combinational result, rs1 XOR rs2.
REQ-008 rd_q  output  XLEN  Registered result of the last accepted operation.
REQ-009 out_valid  output  1  rd_q and flags hold a fresh result for exactly one cycle.
REQ-010 zero  output  1  Registered flag; 1 when the accepted result is all zeros.
REQ-011 parity  output  1  Registered XOR-reduction of the accepted result; 1 for an odd count of set bits.
REQ-012 popcnt  output  $clog2(XLEN)+1  Registered count of set bits in the accepted result, range 0..XLEN.

Function
REQ-013 rd SHALL equal the bitwise XOR of rs1 and rs2 at all times, with zero latency, independent of clk, rst and in_valid.
REQ-014 rd SHALL have no carry, sign or overflow behaviour; every bit i depends only on rs1[i] and rs2[i].
REQ-015 On a rising clk edge with in_valid=1, rd_q SHALL load rs1^rs2, and zero, parity and popcnt SHALL load the values derived from that same result.
REQ-016 out_valid SHALL be 1 in the cycle after an edge that accepted in_valid=1, and 0 otherwise (latency 1, no back-pressure).
REQ-017 With in_valid=0, rd_q, zero, parity and popcnt SHALL hold their previous values.
REQ-018 Back-to-back in_valid=1 SHALL be accepted every cycle at full throughput.
REQ-019 popcnt SHALL saturate naturally at XLEN when the result is all ones; it SHALL never wrap.
REQ-020 parity SHALL equal popcnt[0] for every accepted result.

Reset
REQ-021 While rst=1: rd_q=0, out_valid=0, zero=1, parity=0, popcnt=0, regardless of clk.
REQ-022 Asserting rst in the same cycle as in_valid=1 SHALL discard that operation.
REQ-023 The first in_valid=1 accepted after rst deasserts SHALL behave exactly as in REQ-015.
REQ-024 rst SHALL NOT affect rd.

Structure
REQ-025 The XLEN default and the popcnt width function SHALL be defined in the shared package alu_pkg.
REQ-026 Set-bit counting SHALL be implemented in one sub-module, alu_popcount, a parameterized combinational adder tree.
REQ-027 All other logic SHALL reside in alu_xor, with one clocked process for the registered outputs.

Verification
REQ-028 rs1=0, rs2=0 -> rd=0; after accept: rd_q=0, zero=1, parity=0, popcnt=0.
REQ-029 rs1=0, rs2=0xFFFFFFFF -> rd=0xFFFFFFFF (4294967295); after accept: zero=0, parity=0, popcnt=32.
REQ-030 rs1=0xFFFFFFFF, rs2=0 -> rd=0xFFFFFFFF; rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> rd=0, zero=1.
REQ-031 rs1=0xA5A5A5A5, rs2=0x0000000F -> rd=0xA5A5A5AA; after accept: popcnt=16, parity=0.
REQ-032 in_valid=1 for 3 consecutive cycles with distinct operands -> out_valid=1 for 3 cycles, rd_q tracks each result one cycle late.
REQ-033 rst pulsed mid-stream between clk edges -> registered outputs return to reset values immediately while rd keeps following rs1^rs2.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the XOR ALU slice: default operand
//                width and the width rule for the set-bit count.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Contents
//    XLEN_DEFAULT  default operand / result width in bits
//    popcnt_width  number of bits needed to hold a set-bit count 0..xlen
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // A count of 0..xlen needs one more bit than clog2(xlen): for xlen=32
    // the all-ones result must be representable as 32 without wrapping.
    function automatic int popcnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : alu_popcount
//  Description : Combinational set-bit counter built as a balanced binary
//                adder tree.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     input vector width in bits (>= 1)
//  Ports
//    data_i    input  [WIDTH-1:0]                 vector to count
//    count_o   output [popcnt_width(WIDTH)-1:0]   number of 1 bits, 0..WIDTH
// ============================================================================
module alu_popcount
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN_DEFAULT
) (
    input  logic [WIDTH-1:0]                data_i,
    output logic [popcnt_width(WIDTH)-1:0]  count_o
);

    localparam int OW     = popcnt_width(WIDTH);
    // The tree is padded up to a power-of-two number of leaves; padding
    // leaves are tied to zero so they never contribute to the count.
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    // Level l holds LEAVES>>l partial sums. Every node is carried at the full
    // output width so no intermediate sum can overflow.
    logic [OW-1:0] w_node [LEVELS+1][LEAVES];

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int i = 0; i < LEAVES; i++) begin
                w_node[l][i] = '0;
            end
        end

        for (int i = 0; i < WIDTH; i++) begin
            w_node[0][i] = OW'(data_i[i]);
        end

        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < (LEAVES >> l); i++) begin
                w_node[l][i] = w_node[l-1][2*i] + w_node[l-1][2*i+1];
            end
        end
    end

    assign count_o = w_node[LEVELS][0];

endmodule : alu_popcount
`default_nettype wire

// File: rtl/alu_xor.sv
`default_nettype none
// ============================================================================
//  Module      : alu_xor
//  Description : Bitwise XOR ALU with a zero-latency combinational result and
//                a one-cycle registered result carrying zero / parity /
//                population-count flags.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN       operand and result width in bits
//  Ports
//    clk        input   1        rising-edge clock
//    rst        input   1        asynchronous active-high reset
//    rs1        input   XLEN     source operand 1
//    rs2        input   XLEN     source operand 2
//    in_valid   input   1        operands valid, captured on next clk edge
//    rd         output  XLEN     combinational rs1 ^ rs2
//    rd_q       output  XLEN     registered result of last accepted op
//    out_valid  output  1        one-cycle pulse: registered outputs fresh
//    zero       output  1        registered: accepted result is all zeros
//    parity     output  1        registered: odd number of set bits
//    popcnt     output  clog2(XLEN)+1  registered set-bit count 0..XLEN
// ============================================================================
module alu_xor
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [XLEN-1:0]                rs1,
    input  logic [XLEN-1:0]                rs2,
    input  logic                           in_valid,
    output logic [XLEN-1:0]                rd,
    output logic [XLEN-1:0]                rd_q,
    output logic                           out_valid,
    output logic                           zero,
    output logic                           parity,
    output logic [popcnt_width(XLEN)-1:0]  popcnt
);

    localparam int PCW = popcnt_width(XLEN);

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [PCW-1:0] w_popcnt;
    logic           w_zero;
    logic           w_parity;

    // Pure bitwise XOR: no carries, and untouched by clk, rst or in_valid.
    assign rd = rs1 ^ rs2;

    alu_popcount #(
        .WIDTH   (XLEN)
    ) u_popcount (
        .data_i  (rd),
        .count_o (w_popcnt)
    );

    assign w_zero   = (rd == '0);
    // Parity is taken from an independent XOR reduction rather than the
    // count LSB; the two are equal by construction.
    assign w_parity = ^rd;

    // ------------------------------------------------------------------
    // Next-state selection: load on in_valid, otherwise hold
    // ------------------------------------------------------------------
    logic [XLEN-1:0] result_d, result_q;
    logic            valid_d,  valid_q;
    logic            zero_d,   zero_q;
    logic            parity_d, parity_q;
    logic [PCW-1:0]  popcnt_d, popcnt_q;

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        popcnt_d = popcnt_q;
        // out_valid is a pulse: it follows in_valid with one cycle latency.
        valid_d  = in_valid;

        if (in_valid) begin
            result_d = rd;
            zero_d   = w_zero;
            parity_d = w_parity;
            popcnt_d = w_popcnt;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. Reset values describe an all-zero result, so
    // zero resets to 1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            popcnt_q <= '0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            popcnt_q <= popcnt_d;
        end
    end

    assign rd_q      = result_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign popcnt    = popcnt_q;

endmodule : alu_xor
`default_nettype wire

// File: tb/tb_alu_xor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_xor
//  Description : Self-checking bench for alu_xor (XLEN = 32) using a table of
//                hand-computed vectors plus directed multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_xor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        in_valid;
    logic [31:0] rd;
    logic [31:0] rd_q;
    logic        out_valid;
    logic        zero;
    logic        parity;
    logic [5:0]  popcnt;

    int n_cmp = 0;
    int n_bad = 0;

    alu_xor #(
        .XLEN      (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1       (rs1),
        .rs2       (rs2),
        .in_valid  (in_valid),
        .rd        (rd),
        .rd_q      (rd_q),
        .out_valid (out_valid),
        .zero      (zero),
        .parity    (parity),
        .popcnt    (popcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rd;
        logic        exp_zero;
        logic        exp_parity;
        logic [5:0]  exp_popcnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] e_rdq, input logic e_v,
                            input logic e_z, input logic e_p, input logic [5:0] e_pc);
        chk({tag, ".rd_q"},      64'(rd_q),      64'(e_rdq));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_v));
        chk({tag, ".zero"},      64'(zero),      64'(e_z));
        chk({tag, ".parity"},    64'(parity),    64'(e_p));
        chk({tag, ".popcnt"},    64'(popcnt),    64'(e_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            a             b             rd            z     p     pc
        tbl[0]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 6'd0};
        tbl[1]  = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd32};
        tbl[2]  = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd32};
        tbl[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 6'd0};
        tbl[4]  = '{32'hA5A5A5A5, 32'h0000000F, 32'hA5A5A5AA, 1'b0, 1'b0, 6'd16};
        tbl[5]  = '{32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 6'd1};
        tbl[6]  = '{32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 6'd1};
        tbl[7]  = '{32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0, 1'b0, 6'd16};
        tbl[8]  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 6'd0};
        tbl[9]  = '{32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd32};
        tbl[10] = '{32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 6'd31};

        // ---------------- reset state ----------------
        rst      = 1'b1;
        in_valid = 1'b0;
        rs1      = 32'h0;
        rs2      = 32'h0;
        @(negedge clk);
        chk_regs("reset", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);

        // in_valid during reset is discarded; rd still follows operands
        rs1      = 32'h12345678;
        rs2      = 32'h0000FFFF;
        in_valid = 1'b1;
        #1 chk("reset.rd", 64'(rd), 64'h1234A987);
        @(negedge clk);
        chk_regs("reset_discard", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk_regs("post_reset_idle", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 11; i++) begin
            rs1      = tbl[i].a;
            rs2      = tbl[i].b;
            in_valid = 1'b1;
            #1 chk($sformatf("v%0d.rd", i), 64'(rd), 64'(tbl[i].exp_rd));
            @(negedge clk);
            in_valid = 1'b0;
            chk_regs($sformatf("v%0d", i), tbl[i].exp_rd, 1'b1,
                     tbl[i].exp_zero, tbl[i].exp_parity, tbl[i].exp_popcnt);
            // operands change while idle: registered outputs must hold
            rs1 = ~tbl[i].a;
            rs2 = 32'h13579BDF;
            @(negedge clk);
            chk_regs($sformatf("v%0d_hold", i), tbl[i].exp_rd, 1'b0,
                     tbl[i].exp_zero, tbl[i].exp_parity, tbl[i].exp_popcnt);
        end

        // ---------------- back-to-back, 3 cycles ----------------
        rs1 = 32'h00000003; rs2 = 32'h00000000; in_valid = 1'b1;   // 3: pc2 p0
        @(negedge clk);
        chk_regs("b2b0", 32'h00000003, 1'b1, 1'b0, 1'b0, 6'd2);
        rs1 = 32'hF0000000; rs2 = 32'h10000000;                    // E0000000: pc3 p1
        @(negedge clk);
        chk_regs("b2b1", 32'hE0000000, 1'b1, 1'b0, 1'b1, 6'd3);
        rs1 = 32'hCAFEF00D; rs2 = 32'hCAFEF00D;                    // 0
        @(negedge clk);
        chk_regs("b2b2", 32'h00000000, 1'b1, 1'b1, 1'b0, 6'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk_regs("b2b_end", 32'h00000000, 1'b0, 1'b1, 1'b0, 6'd0);

        // ---------------- reset mid-stream, between edges ----------------
        rs1 = 32'h00000070; rs2 = 32'h00000000; in_valid = 1'b1;   // pc3 p1
        @(negedge clk);
        chk_regs("pre_rst", 32'h00000070, 1'b1, 1'b0, 1'b1, 6'd3);
        #2 rst = 1'b1;
        #1 chk_regs("async_rst", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);
        rs1 = 32'h0000FF00; rs2 = 32'h00000F00;
        #1 chk("rst.rd", 64'(rd), 64'h0000F000);
        @(negedge clk);
        // in_valid stayed high across an edge under reset: discarded
        chk_regs("rst_hold", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);

        // first accept after release
        rst = 1'b0;
        rs1 = 32'h0000000F; rs2 = 32'h00000001;                    // E: pc3 p1
        @(negedge clk);
        in_valid = 1'b0;
        chk_regs("first_after_rst", 32'h0000000E, 1'b1, 1'b0, 1'b1, 6'd3);
        @(negedge clk);
        chk_regs("first_after_rst_hold", 32'h0000000E, 1'b0, 1'b0, 1'b1, 6'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_xor
`default_nettype wire
